instr_fetch: RTL

- Fetch stage directly upstream of instruction decode. Holds the PC and issues word requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned words with their PC in a small flush-able FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute. On a redirect it discards every stale word, whether buffered or still in flight.

---
 rtl/friscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/instr_fetch.sv | 107 ++++++++++
 3 files changed

// File: rtl/friscv_pkg.sv
// Shared fetch-path types and constants.
`default_nettype none

package friscv_pkg;

  localparam int ARCH = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [ARCH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ARCH-1:0] pc;
    logic [ARCH-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// Flushable synchronous FIFO of fetched {pc, instr} entries.
`default_nettype none

module fetch_fifo
  import friscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  // Writing the slot being popped is safe: the old head is read combinationally.
  assign do_push = push & (~full | do_pop) & ~flush;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// Fetch stage: PC generation, imem req/gnt/rvalid issue, credit-limited
// buffering of returned words, and redirect flush with in-flight discard.
`default_nettype none

module instr_fetch
  import friscv_pkg::*;
#(
  parameter logic [ARCH-1:0] RESET_PC = 32'h0000_0000,
  parameter int FETCH_BUF_DEPTH = 4,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_out,
  output logic [ARCH-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [ARCH-1:0] imem_rdata_in,
  input  logic            redirect_in,
  input  logic [ARCH-1:0] redirect_pc_in,
  output logic            instr_valid_out,
  input  logic            instr_ready_in,
  output logic [ARCH-1:0] instr_out,
  output logic [ARCH-1:0] pc_out
);

  localparam int CW = $clog2(FETCH_BUF_DEPTH + MAX_INFLIGHT + 1);
  localparam int AW = $clog2(FETCH_BUF_DEPTH);

  logic [ARCH-1:0] fetch_pc_q;
  logic [ARCH-1:0] resp_pc_q;
  logic [CW-1:0]   inflight_q;
  logic [CW-1:0]   inflight_d;
  logic [CW-1:0]   discard_q;
  logic [CW-1:0]   occupancy;
  logic [ARCH-1:0] target_pc;
  logic [AW:0]     fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            fire;
  logic            drop;
  logic            push;

  assign pop        = instr_valid_out & instr_ready_in;
  assign occupancy  = inflight_q + CW'(fifo_count) - CW'(pop);
  assign imem_req_out = ~rst & ~redirect_in
                      & (inflight_q < CW'(MAX_INFLIGHT))
                      & (occupancy < CW'(FETCH_BUF_DEPTH));
  assign imem_addr_out = fetch_pc_q;
  assign fire       = imem_req_out & imem_gnt_in;
  assign inflight_d = inflight_q + CW'(fire) - CW'(imem_rvalid_in);
  assign drop       = imem_rvalid_in & (discard_q != '0);
  assign push       = imem_rvalid_in & ~redirect_in & ~drop;
  assign target_pc  = redirect_pc_in & ~ARCH'(3);
  assign push_entry = '{pc: resp_pc_q, instr: imem_rdata_in};

  fetch_fifo #(.DEPTH(FETCH_BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_in),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Every request still unanswered after a redirect belongs to the old stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (redirect_in) begin
        fetch_pc_q <= target_pc;
        resp_pc_q  <= target_pc;
        discard_q  <= inflight_d;
      end else begin
        if (fire) fetch_pc_q <= fetch_pc_q + ARCH'(INSTR_BYTES);
        if (drop) discard_q  <= discard_q - 1'b1;
        if (push) resp_pc_q  <= resp_pc_q + ARCH'(INSTR_BYTES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && fifo_full));
      assert (!(imem_rvalid_in && inflight_q == '0));
    end
  end

  assign instr_valid_out = ~fifo_empty;
  assign instr_out       = fifo_empty ? '0 : fifo_head.instr;
  assign pc_out          = fifo_empty ? '0 : fifo_head.pc;

endmodule

`default_nettype wire
